// File: rtl/vtree_stage_scheduler_pkg.sv
// ============================================================================
// Module   : vtree_stage_scheduler_pkg
// Purpose  : Shared definitions for the virtual merge-tree stage scheduler:
//            the node-count macro, a clog2 helper and the key comparator.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Number of logical merge nodes owned by a stage with 2^W_LOG input ways.
`ifndef N_OF
`define N_OF(W_LOG) (1 << ((W_LOG) - 1))
`endif

package vtree_stage_scheduler_pkg;

  // Widest key the comparator accepts; narrower keys are zero-extended.
  localparam int c_key_max_w = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Unsigned key compare; returns 1 when a is strictly smaller than b.
  function automatic logic key_lt(input logic [c_key_max_w-1:0] a,
                                  input logic [c_key_max_w-1:0] b);
    return (a < b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vtree_stage_scheduler_arbiter.sv
// ============================================================================
// Module   : vtree_rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches the request vector
//            starting at i_ptr and returns the first requesting index.
// Ports    : i_req     - N request lines
//            i_ptr     - search start index
//            o_gnt_idx - granted index (0 when nothing granted)
//            o_gnt_vld - a request was granted
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vtree_rr_arbiter
  import vtree_stage_scheduler_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_gnt_vld
);

  logic [IW-1:0] w_idx;

  // Walk offsets from the far end toward the pointer so the requester
  // closest to i_ptr is the last one written and therefore wins. N is a
  // power of two, so the IW-bit add wraps the search naturally.
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    w_idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = i_ptr + IW'(i);
      if (i_req[w_idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vtree_stage_scheduler.sv
// ============================================================================
// Module   : vtree_stage_scheduler
// Purpose  : Scheduler for one stage of a time-multiplexed merge tree. Each
//            cycle S1 grants one eligible node round-robin and reads its two
//            heads; S2 compares the keys, pops the smaller head and forwards
//            it to the node's downstream channel.
// Ports    : CLK, RST       - clock, synchronous active-high reset
//            EMP0/EMP1      - per-node empty flags, even/odd input channels
//            DN_FULL        - per-node downstream full flags
//            RD_IDX         - node index presented to the input BRAM reads
//            DIN0/DIN1      - even/odd heads, one cycle after RD_IDX
//            POP0/POP1      - pop even/odd head of node POP_IDX
//            POP_IDX        - node being popped
//            DOUT/DOUT_VLD  - merged record and its enqueue strobe
//            DOUT_IDX       - downstream channel (same as POP_IDX)
//            STALLS         - saturating count of cycles with work but no grant
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vtree_stage_scheduler
  import vtree_stage_scheduler_pkg::*;
#(
  parameter int W_LOG = 2,
  parameter int DATW  = 64,
  parameter int KEYW  = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [`N_OF(W_LOG)-1:0] EMP0,
  input  logic [`N_OF(W_LOG)-1:0] EMP1,
  input  logic [`N_OF(W_LOG)-1:0] DN_FULL,
  output logic [W_LOG-2:0]        RD_IDX,
  input  logic [DATW-1:0]         DIN0,
  input  logic [DATW-1:0]         DIN1,
  output logic                    POP0,
  output logic                    POP1,
  output logic [W_LOG-2:0]        POP_IDX,
  output logic [DATW-1:0]         DOUT,
  output logic                    DOUT_VLD,
  output logic [W_LOG-2:0]        DOUT_IDX,
  output logic [31:0]             STALLS
);

  localparam int c_n  = `N_OF(W_LOG);
  localparam int c_iw = W_LOG - 1;

  logic             r_s2_vld;
  logic [c_iw-1:0]  r_s2_idx;
  logic [c_iw-1:0]  r_rr_ptr;
  logic [c_iw-1:0]  r_rd_idx;
  logic [31:0]      r_stalls;

  logic [c_n-1:0]   w_elig;
  logic [c_n-1:0]   w_ready;
  logic [c_iw-1:0]  w_gnt_idx;
  logic             w_gnt_vld;
  logic             w_issue;
  logic             w_emit;
  logic             w_lt;

  // A node whose previous record is still in S2 is excluded, so the flags
  // seen here already include that record's pop and enqueue.
  for (genvar c = 0; c < c_n; c++) begin : g_elig
    assign w_ready[c] = ~EMP0[c] & ~EMP1[c];
    assign w_elig[c]  = w_ready[c] & ~DN_FULL[c] &
                        ~(r_s2_vld && (r_s2_idx == c_iw'(c)));
  end

  vtree_rr_arbiter #(
    .N  (c_n),
    .IW (c_iw)
  ) u_arb (
    .i_req     (w_elig),
    .i_ptr     (r_rr_ptr),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  assign w_issue = w_gnt_vld & ~RST;
  assign RD_IDX  = w_issue ? w_gnt_idx : r_rd_idx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s2_vld <= 1'b0;
      r_s2_idx <= '0;
      r_rr_ptr <= '0;
      r_rd_idx <= '0;
      r_stalls <= '0;
    end else begin
      r_s2_vld <= w_issue;
      if (w_issue) begin
        r_s2_idx <= w_gnt_idx;
        r_rd_idx <= w_gnt_idx;
        r_rr_ptr <= w_gnt_idx + 1'b1;
      end
      if (!w_issue && (|w_ready) && (r_stalls != '1)) begin
        r_stalls <= r_stalls + 32'd1;
      end
    end
  end

  // S2: a tie pops the odd side. Reset squashes a record in flight so the
  // buffers, which reset in the same cycle, see no pop or enqueue.
  assign w_lt     = key_lt(c_key_max_w'(DIN0[KEYW-1:0]),
                           c_key_max_w'(DIN1[KEYW-1:0]));
  assign w_emit   = r_s2_vld & ~RST;
  assign POP0     = w_emit & w_lt;
  assign POP1     = w_emit & ~w_lt;
  assign DOUT_VLD = w_emit;
  assign DOUT     = w_emit ? (w_lt ? DIN0 : DIN1) : '0;
  assign POP_IDX  = RST ? '0 : r_s2_idx;
  assign DOUT_IDX = POP_IDX;
  assign STALLS   = r_stalls;

endmodule

`default_nettype wire

// File: tb/tb_vtree_stage_scheduler.sv
// ============================================================================
// Module   : tb_vtree_stage_scheduler
// Purpose  : Self-checking bench for vtree_stage_scheduler. Models the input
//            buffer layers as per-node queues with a registered read and the
//            downstream layer as per-channel queues; checks directed cases
//            and a randomized merge against a list-merge reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vtree_stage_scheduler;

  localparam int W_LOG = 3;
  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int DATW  = 64;
  localparam int KEYW  = 32;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    EMP0, EMP1, DN_FULL;
  logic [IW-1:0]   RD_IDX, POP_IDX, DOUT_IDX;
  logic [DATW-1:0] DIN0, DIN1, DOUT;
  logic            POP0, POP1, DOUT_VLD;
  logic [31:0]     STALLS;

  vtree_stage_scheduler #(.W_LOG(W_LOG), .DATW(DATW), .KEYW(KEYW)) dut (
    .CLK(CLK), .RST(RST), .EMP0(EMP0), .EMP1(EMP1), .DN_FULL(DN_FULL),
    .RD_IDX(RD_IDX), .DIN0(DIN0), .DIN1(DIN1), .POP0(POP0), .POP1(POP1),
    .POP_IDX(POP_IDX), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_IDX(DOUT_IDX),
    .STALLS(STALLS)
  );

  always #5 CLK = ~CLK;

  // Buffer layers and downstream channels.
  logic [63:0] q0[N][$];
  logic [63:0] q1[N][$];
  logic [63:0] dq[N][$];
  logic [63:0] expq[N][$];

  // Per-emit log.
  logic [63:0]   lg_dout[$];
  logic          lg_p0[$];
  logic          lg_p1[$];
  logic [IW-1:0] lg_idx[$];
  int            lg_cyc[$];

  // Outputs sampled on the last falling edge.
  logic          s_p0, s_p1, s_vld;
  logic [IW-1:0] s_pidx, s_didx, s_rd;
  logic [63:0]   s_dout;
  logic [31:0]   s_stall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rand_full = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rec(input logic [31:0] tag, input logic [31:0] key);
    return {tag, key};
  endfunction

  function automatic void refresh();
    for (int c = 0; c < N; c++) begin
      EMP0[c] = (q0[c].size() == 0);
      EMP1[c] = (q1[c].size() == 0);
    end
  endfunction

  function automatic void clear_all();
    for (int c = 0; c < N; c++) begin
      q0[c].delete(); q1[c].delete(); dq[c].delete();
    end
    refresh();
  endfunction

  function automatic void clear_log();
    lg_dout.delete(); lg_p0.delete(); lg_p1.delete();
    lg_idx.delete();  lg_cyc.delete();
  endfunction

  // One clock: sample on the falling edge, then apply pops, enqueues and
  // the registered head read just after the rising edge.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    s_p0 = POP0; s_p1 = POP1; s_vld = DOUT_VLD; s_pidx = POP_IDX;
    s_didx = DOUT_IDX; s_dout = DOUT; s_rd = RD_IDX; s_stall = STALLS;
    if (s_vld) begin
      lg_dout.push_back(s_dout); lg_p0.push_back(s_p0); lg_p1.push_back(s_p1);
      lg_idx.push_back(s_didx);  lg_cyc.push_back(cyc);
    end
    @(posedge CLK);
    #1;
    if (s_p0) begin
      if (q0[s_pidx].size() == 0) chk("pop0_on_empty", 64'd1, 64'd0);
      else void'(q0[s_pidx].pop_front());
    end
    if (s_p1) begin
      if (q1[s_pidx].size() == 0) chk("pop1_on_empty", 64'd1, 64'd0);
      else void'(q1[s_pidx].pop_front());
    end
    if (s_vld) dq[s_didx].push_back(s_dout);
    DIN0 = (q0[s_rd].size() != 0) ? q0[s_rd][0] : 64'd0;
    DIN1 = (q1[s_rd].size() != 0) ? q1[s_rd][0] : 64'd0;
    if (rand_full) begin
      for (int c = 0; c < N; c++) DN_FULL[c] = ($urandom_range(0, 9) < 3);
    end
    refresh();
  endtask

  task automatic drain();
    DN_FULL = '1;
    tick(); tick();
    clear_all();
    DN_FULL = '0;
    clear_log();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_all();
    tick(); tick();
    RST = 1'b0;
    clear_log();
  endtask

  function automatic bit busy();
    for (int c = 0; c < N; c++)
      if (q0[c].size() != 0 && q1[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] e1_key [4];
    logic        e1_p1  [4];
    logic [31:0] s0;
    logic [63:0] a[$];
    logic [63:0] b[$];
    int          bound;
    int          k;
    int          len;

    e1_key = '{32'd1, 32'd2, 32'd3, 32'd4};
    e1_p1  = '{1'b0, 1'b1, 1'b1, 1'b0};
    RST = 1'b1; DN_FULL = '0; DIN0 = '0; DIN1 = '0;
    clear_all();

    // Reset state.
    tick(); tick();
    chk("rst_pop0", 64'(s_p0), 64'd0);
    chk("rst_pop1", 64'(s_p1), 64'd0);
    chk("rst_vld", 64'(s_vld), 64'd0);
    chk("rst_dout", s_dout, 64'd0);
    chk("rst_pop_idx", 64'(s_pidx), 64'd0);
    chk("rst_dout_idx", 64'(s_didx), 64'd0);
    chk("rst_rd_idx", 64'(s_rd), 64'd0);
    chk("rst_stalls", 64'(s_stall), 64'd0);
    RST = 1'b0;
    clear_log();

    // Single node: merge 1,4 with 2,3; only one node eligible so every
    // other cycle.
    q0[0] = '{rec(32'hA1, 32'd1), rec(32'hA4, 32'd4), rec(32'hAE, 32'hFFFF_FFFF)};
    q1[0] = '{rec(32'hB2, 32'd2), rec(32'hB3, 32'd3), rec(32'hBF, 32'hFFFF_FFFF)};
    refresh();
    repeat (9) tick();
    chk("t1_count", 64'(lg_dout.size()), 64'd4);
    for (int i = 0; i < 4 && i < lg_dout.size(); i++) begin
      chk("t1_key", 64'(lg_dout[i][31:0]), 64'(e1_key[i]));
      chk("t1_pop1", 64'(lg_p1[i]), 64'(e1_p1[i]));
      chk("t1_pop0", 64'(lg_p0[i]), 64'(!e1_p1[i]));
      chk("t1_idx", 64'(lg_idx[i]), 64'd0);
      if (i > 0) chk("t1_gap", 64'(lg_cyc[i] - lg_cyc[i-1]), 64'd2);
    end
    drain();

    // Two busy nodes: back-to-back, alternating grants.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0[0].push_back(rec(32'h00, 32'(10 + 2*i)));
      q1[0].push_back(rec(32'h01, 32'(11 + 2*i)));
      q0[1].push_back(rec(32'h10, 32'(20 + 2*i)));
      q1[1].push_back(rec(32'h11, 32'(21 + 2*i)));
    end
    refresh();
    repeat (9) tick();
    chk("t2_count", 64'(lg_dout.size()), 64'd8);
    for (int i = 0; i < lg_dout.size(); i++) begin
      chk("t2_idx", 64'(lg_idx[i]), 64'(i % 2));
      if (i > 0) chk("t2_gap", 64'(lg_cyc[i] - lg_cyc[i-1]), 64'd1);
    end
    drain();

    // Equal keys pop the odd side.
    q0[1] = '{rec(32'hE0, 32'd5)};
    q1[1] = '{rec(32'hD0, 32'd5)};
    refresh();
    repeat (3) tick();
    chk("t3_count", 64'(lg_dout.size()), 64'd1);
    if (lg_dout.size() > 0) begin
      chk("t3_pop1", 64'(lg_p1[0]), 64'd1);
      chk("t3_pop0", 64'(lg_p0[0]), 64'd0);
      chk("t3_dout", lg_dout[0], rec(32'hD0, 32'd5));
      chk("t3_idx", 64'(lg_idx[0]), 64'd1);
    end
    drain();

    // Downstream full blocks node 0 and counts stalls.
    DN_FULL = 4'b0001;
    q0[0] = '{rec(32'h1, 32'd1), rec(32'h2, 32'd2)};
    q1[0] = '{rec(32'h3, 32'd3), rec(32'h4, 32'd4)};
    refresh();
    tick();
    s0 = s_stall;
    repeat (4) tick();
    chk("t4_stalls", 64'(s_stall), 64'(s0 + 32'd4));
    chk("t4_no_emit", 64'(lg_dout.size()), 64'd0);
    DN_FULL = '0;
    tick();
    chk("t4_grant_rd", 64'(s_rd), 64'd0);
    tick();
    chk("t4_emit_count", 64'(lg_dout.size()), 64'd1);
    if (lg_dout.size() > 0) chk("t4_emit_idx", 64'(lg_idx[0]), 64'd0);
    drain();

    // Reset with a record in flight.
    q0[0] = '{rec(32'h1, 32'd7)};
    q1[0] = '{rec(32'h2, 32'd8)};
    refresh();
    tick();
    RST = 1'b1;
    clear_all();
    tick();
    chk("t5_pop0", 64'(s_p0), 64'd0);
    chk("t5_pop1", 64'(s_p1), 64'd0);
    chk("t5_vld", 64'(s_vld), 64'd0);
    RST = 1'b0;
    tick();
    chk("t5_pop_idx", 64'(s_pidx), 64'd0);
    chk("t5_dout_idx", 64'(s_didx), 64'd0);
    chk("t5_dout", s_dout, 64'd0);
    chk("t5_rd_idx", 64'(s_rd), 64'd0);
    chk("t5_stalls", 64'(s_stall), 64'd0);
    clear_log();
    // Pointer back at 0: with nodes 0 and 3 ready, node 0 wins first.
    q0[0] = '{rec(32'h1, 32'd1)}; q1[0] = '{rec(32'h2, 32'd2)};
    q0[3] = '{rec(32'h3, 32'd1)}; q1[3] = '{rec(32'h4, 32'd2)};
    refresh();
    repeat (3) tick();
    chk("t5_first_count", 64'(lg_dout.size() >= 1), 64'd1);
    if (lg_dout.size() > 0) chk("t5_first_idx", 64'(lg_idx[0]), 64'd0);
    drain();

    // Randomized sorted runs with random downstream back-pressure.
    do_reset();
    for (int c = 0; c < N; c++) begin
      a.delete(); b.delete();
      for (int s = 0; s < 2; s++) begin
        len = $urandom_range(1, 10);
        k = $urandom_range(0, 5);
        for (int i = 0; i < len; i++) begin
          if (s == 0) begin
            q0[c].push_back(rec(32'((s << 12) | (c << 8) | i), 32'(k)));
            a.push_back(rec(32'((s << 12) | (c << 8) | i), 32'(k)));
          end else begin
            q1[c].push_back(rec(32'((s << 12) | (c << 8) | i), 32'(k)));
            b.push_back(rec(32'((s << 12) | (c << 8) | i), 32'(k)));
          end
          k += $urandom_range(0, 3);
        end
      end
      // Reference: emit the smaller head (odd on a tie) while both lists
      // still hold records.
      expq[c].delete();
      while (a.size() != 0 && b.size() != 0) begin
        if (a[0][31:0] < b[0][31:0]) expq[c].push_back(a.pop_front());
        else                         expq[c].push_back(b.pop_front());
      end
    end
    refresh();
    rand_full = 1'b1;
    bound = 0;
    while (busy() && bound < 4000) begin
      tick();
      bound++;
    end
    chk("t6_timeout", 64'(bound < 4000), 64'd1);
    rand_full = 1'b0;
    DN_FULL = '0;
    repeat (3) tick();
    for (int c = 0; c < N; c++) begin
      chk("t6_len", 64'(dq[c].size()), 64'(expq[c].size()));
      for (int i = 0; i < dq[c].size() && i < expq[c].size(); i++) begin
        chk("t6_rec", dq[c][i], expq[c][i]);
        if (i > 0) chk("t6_order", 64'(dq[c][i][31:0] >= dq[c][i-1][31:0]), 64'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
